fp_normalize_28bit: RTL

FP_NORMALIZE_28BIT -- requirements
Module: fp_normalize_28bit

---
 rtl/fp_normalize_28bit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fp_normalize_28bit.sv
// fp_normalize_28bit: post-add significand normalizer for a 28-bit
// carry/hidden/fraction significand with an 8-bit biased exponent.
//   clk, reset          : clock, synchronous active-high reset
//   start               : capture sig_in/exp_in when idle
//   sig_in[27:0]        : bit 27 carry, bit 26 hidden one, 25:0 fraction+GRS
//   exp_in[7:0]         : biased exponent
//   busy, done          : operation in progress / one-cycle result strobe
//   sig_out, exp_out    : normalized significand and adjusted exponent
//   zero, overflow, underflow : result classification, valid with done
// Build option: define FP_NORM_LZC_EN to replace the one-bit-per-cycle left
// shift with a single leading-zero-count shift (same results, lower latency).
module fp_normalize_28bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [27:0] sig_in,
  input  logic [7:0]  exp_in,
  output logic        busy,
  output logic        done,
  output logic [27:0] sig_out,
  output logic [7:0]  exp_out,
  output logic        zero,
  output logic        overflow,
  output logic        underflow
);

  localparam int unsigned SIG_W = 28;
  localparam int unsigned EXP_W = 8;

  typedef enum logic {IDLE = 1'b0, NORM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SIG_W-1:0]   sig_out_q, sig_out_d;
  logic [EXP_W-1:0]   exp_out_q, exp_out_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               accept;
  logic               sig_zero, carry, hidden, exp_low, finish;
  logic [EXP_W-1:0]   shamt;

  // A start coinciding with the done strobe is dropped.
  assign accept   = (state_q == IDLE) && start && !done_q;
  assign sig_zero = (sig_q == '0);
  assign carry    = sig_q[SIG_W-1];
  assign hidden   = sig_q[SIG_W-2];
  assign exp_low  = (exp_q <= 8'd1);
  assign finish   = (state_q == NORM) && (sig_zero || carry || hidden || exp_low);

`ifdef FP_NORM_LZC_EN
  logic [4:0]         lzc;
  logic [EXP_W-1:0]   lzc_m1, exp_m1;

  // Leading-zero count of the working significand.
  always_comb begin
    lzc = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (sig_q[i]) lzc = 5'(27 - i);
    end
  end

  // Shift just far enough to reach the hidden position, but never below exponent 1.
  assign lzc_m1 = EXP_W'(lzc) - 8'd1;
  assign exp_m1 = exp_q - 8'd1;
  assign shamt  = (lzc_m1 < exp_m1) ? lzc_m1 : exp_m1;
`else
  assign shamt  = 8'd1;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sig_q     <= '0;
      exp_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sig_out_q <= '0;
      exp_out_q <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      exp_q     <= exp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sig_out_q <= sig_out_d;
      exp_out_q <= exp_out_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = NORM;
      NORM:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic: one priority-ordered action per NORM cycle.
  always_comb begin
    sig_d     = sig_q;
    exp_d     = exp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sig_out_d = sig_out_q;
    exp_out_d = exp_out_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (accept) begin
      sig_d  = sig_in;
      exp_d  = exp_in;
      busy_d = 1'b1;
      zero_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else if (state_q == NORM) begin
      if (finish) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      if (sig_zero) begin
        zero_d    = 1'b1;
        sig_out_d = '0;
        exp_out_d = '0;
      end else if (carry) begin
        // Exponent 254 (or above) cannot absorb the carry: saturate to overflow.
        if (exp_q >= 8'd254) begin
          ovf_d     = 1'b1;
          sig_out_d = '0;
          exp_out_d = 8'd255;
        end else begin
          sig_out_d = {1'b0, sig_q[SIG_W-1:1]} | {{(SIG_W-1){1'b0}}, sig_q[0]};
          exp_out_d = exp_q + 8'd1;
        end
      end else if (hidden) begin
        sig_out_d = sig_q;
        exp_out_d = exp_q;
      end else if (exp_low) begin
        unf_d     = 1'b1;
        sig_out_d = sig_q;
        exp_out_d = exp_q;
      end else begin
        sig_d = sig_q << shamt;
        exp_d = exp_q - shamt;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sig_out   = sig_out_q;
  assign exp_out   = exp_out_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
